// File: rtl/cmp_minmax_seq.sv
// Running min/max/count over a framed sample stream, using one shared external
// magnitude comparator for two compares per sample. Any inconsistent flag vector sets a sticky error.
module cmp_minmax_seq #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned COUNT_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [DATA_W-1:0]  in_data_i,
    input  logic               in_last_i,
    output logic [DATA_W-1:0]  cmp_a_o,
    output logic [DATA_W-1:0]  cmp_b_o,
    input  logic [5:0]         cmp_y_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [DATA_W-1:0]  out_min_o,
    output logic [DATA_W-1:0]  out_max_o,
    output logic [COUNT_W-1:0] out_count_o,
    output logic               out_err_o
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StWait   = 3'd1;
    localparam logic [2:0] StCmpMax = 3'd2;
    localparam logic [2:0] StCmpMin = 3'd3;
    localparam logic [2:0] StDone   = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [DATA_W-1:0]  min_q, min_d;
    logic [DATA_W-1:0]  max_q, max_d;
    logic [DATA_W-1:0]  sample_q, sample_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               last_q, last_d;
    logic               err_q, err_d;

    logic flag_eq, flag_ne, flag_gt, flag_lt, flag_ge, flag_le;
    logic flags_bad;
    logic in_xfer;

    assign {flag_eq, flag_ne, flag_gt, flag_lt, flag_ge, flag_le} = cmp_y_i;

    // Exactly one of eq/gt/lt must hold; the other three flags are derived from them.
    always_comb begin
        flags_bad = (flag_ne != ~flag_eq)
                  | (flag_ge != (flag_gt | flag_eq))
                  | (flag_le != (flag_lt | flag_eq))
                  | (({1'b0, flag_eq} + {1'b0, flag_gt} + {1'b0, flag_lt}) != 2'd1);
    end

    assign in_ready_o  = rst_ni && ((state_q == StIdle) || (state_q == StWait));
    assign in_xfer     = in_valid_i && in_ready_o;
    assign out_valid_o = (state_q == StDone);
    assign out_min_o   = min_q;
    assign out_max_o   = max_q;
    assign out_count_o = count_q;
    assign out_err_o   = err_q;

    always_comb begin
        cmp_a_o = '0;
        cmp_b_o = '0;
        if (state_q == StCmpMax) begin
            cmp_a_o = sample_q;
            cmp_b_o = max_q;
        end else if (state_q == StCmpMin) begin
            cmp_a_o = sample_q;
            cmp_b_o = min_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        min_d    = min_q;
        max_d    = max_q;
        sample_d = sample_q;
        count_d  = count_q;
        last_d   = last_q;
        err_d    = err_q;
        case (state_q)
            StIdle: begin
                if (in_xfer) begin
                    min_d   = in_data_i;
                    max_d   = in_data_i;
                    count_d = COUNT_W'(1);
                    err_d   = 1'b0;
                    state_d = in_last_i ? StDone : StWait;
                end
            end
            StWait: begin
                if (in_xfer) begin
                    sample_d = in_data_i;
                    last_d   = in_last_i;
                    if (count_q != {COUNT_W{1'b1}}) begin
                        count_d = count_q + COUNT_W'(1);
                    end
                    state_d = StCmpMax;
                end
            end
            StCmpMax: begin
                if (flag_gt) begin
                    max_d = sample_q;
                end
                if (flags_bad) begin
                    err_d = 1'b1;
                end
                state_d = StCmpMin;
            end
            StCmpMin: begin
                if (flag_lt) begin
                    min_d = sample_q;
                end
                if (flags_bad) begin
                    err_d = 1'b1;
                end
                state_d = last_q ? StDone : StWait;
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            min_q    <= '0;
            max_q    <= '0;
            sample_q <= '0;
            count_q  <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            min_q    <= min_d;
            max_q    <= max_d;
            sample_q <= sample_d;
            count_q  <= count_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/cmp_minmax_seq.md
Name: cmp_minmax_seq

Overview:
- Sequential client of the 6-flag magnitude comparator: drives operand pairs onto the comparator's A/B inputs and consumes its Y flag vector.
- Tracks running minimum and maximum over a framed stream of unsigned samples, then presents a min/max/count result on a valid/ready handshake.
- Time-multiplexes one external comparator, two compares per sample, and sticky-flags any inconsistent flag vector as a comparator fault.

Parameters:
- DATA_W, 4, sample and operand width; matches comparator A/B width.
- COUNT_W, 8, sample counter width; saturates at 2^COUNT_W-1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample offered.
- in_ready  out  1  block accepts sample this cycle.
- in_data  in  DATA_W  unsigned sample.
- in_last  in  1  marks the final sample of a frame; qualified by in_valid&in_ready.
- cmp_a  out  DATA_W  operand A to comparator.
- cmp_b  out  DATA_W  operand B to comparator.
- cmp_y  in  6  comparator flags, combinational same cycle: [5] eq, [4] ne, [3] gt, [2] lt, [1] ge, [0] le.
- out_valid  out  1  result available.
- out_ready  in  1  downstream accepts the result.
- out_min  out  DATA_W  frame minimum.
- out_max  out  DATA_W  frame maximum.
- out_count  out  COUNT_W  samples in frame, saturating.
- out_err  out  1  one or more inconsistent flag vectors seen during the frame.

Behaviour:
- Reset (async, rst_n=0): state IDLE. in_ready=0 while rst_n=0, then 1 in IDLE. out_valid=0. out_min, out_max, out_count, out_err=0. cmp_a=cmp_b=0. Internal sample/last registers=0.
- A reset mid-frame discards the partial frame. No result is emitted.
- Transfer rule: in_valid&in_ready on a rising edge. in_ready=1 only in IDLE and WAIT. Result handshake: out_valid&out_ready.
- States:
  - IDLE: on transfer, min=max=in_data, count=1, err=0. Go to DONE if in_last=1, else WAIT.
  - WAIT: on transfer, latch sample and last, count+1 (saturating), go to CMP_MAX. No transfer: stay.
  - CMP_MAX: cmp_a=sample, cmp_b=max. If cmp_y[3]=1, max<=sample. Go to CMP_MIN.
  - CMP_MIN: cmp_a=sample, cmp_b=min. If cmp_y[2]=1, min<=sample. Go to DONE if latched last=1, else WAIT.
  - DONE: out_valid=1 and outputs stable. On out_ready, go to IDLE next cycle. out_valid drops and result registers hold their last values.
- cmp_a/cmp_b are 0 outside CMP_MAX and CMP_MIN.
- Throughput: 3 cycles per non-first sample (accept, CMP_MAX, CMP_MIN).
- Latency: last accept to out_valid = 3 cycles. A single-sample frame gives out_valid 1 cycle after accept.
- Equal samples: neither gt nor lt asserts, so min/max are unchanged.
- Consistency check, evaluated in CMP_MAX and CMP_MIN only. Set sticky err if any of these hold:
  - cmp_y[4] != ~cmp_y[5]
  - cmp_y[1] != (cmp_y[3]|cmp_y[5])
  - cmp_y[0] != (cmp_y[2]|cmp_y[5])
  - the count of set bits among {eq, gt, lt} != 1
- On an inconsistent vector, min/max still update per the gt/lt bits as driven.
- err clears only at the IDLE first-sample load.
- Counter saturates at all-ones and never wraps.
- in_last on a sample sets end-of-frame. Frames with no in_last stay open indefinitely.

Test Plan:
- Frame 5,2,9,2(last) with a correct comparator model -> out_min=2, out_max=9, out_count=4, out_err=0, out_valid 3 cycles after last accept.
- Single sample 7 with in_last=1 -> out_valid next cycle, min=max=7, count=1. in_ready low until out_ready handshake.
- Frame 15,0,15,0(last) -> min=0, max=15, count=4. Hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0 throughout.
- Comparator model forced to return 6'b110000 (eq and ne both set) during one compare -> out_err=1 for that frame. Next frame with correct model -> out_err=0.
- COUNT_W=2, frame of 5 samples of 3 -> out_count=3 (saturated), min=max=3.
- Assert rst_n=0 during CMP_MAX of a 3-sample frame -> all outputs 0 immediately, no out_valid. Next frame 4,1(last) -> min=1, max=4, count=2.
